// File: rtl/cpu_pkg.sv
// Shared definitions for the PLP CPU pipeline: fetch-state encoding and
// architectural constants.
package cpu_pkg;

    typedef enum logic [1:0] {
        StFetch   = 2'd0,
        StHold    = 2'd1,
        StDiscard = 2'd2
    } if_state_t;

    localparam logic [31:0] NOP_INST          = 32'h0000_0000;
    localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0000_0000;

    // Redirect target: jump wins over branch, forced to a word boundary.
    function automatic logic [31:0] redirect_target(input logic        c_j,
                                                    input logic [31:0] baddr,
                                                    input logic [31:0] jaddr);
        logic [31:0] t;
        t = c_j ? jaddr : baddr;
        return {t[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/cpu_if.sv
// Instruction fetch stage: owns the PC, drives the instruction-memory
// request/ack port and loads the IF/ID register (p_inst, p_pc).
module cpu_if
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = RESET_VEC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        c_b,
    input  logic        c_j,
    input  logic [31:0] baddr,
    input  logic [31:0] jaddr,
    output logic        i_req,
    output logic [31:0] i_addr,
    input  logic        i_ack,
    input  logic [31:0] i_data,
    output logic [31:0] p_inst,
    output logic [31:0] p_pc
);

    if_state_t   state;
    logic [31:0] pc;
    logic [31:0] req_addr;
    logic [31:0] buf_inst;
    logic [31:0] buf_pc;
    logic        redir;
    logic [31:0] target;
    logic [31:0] next_addr;

    assign redir     = c_j | c_b;
    assign target    = redirect_target(c_j, baddr, jaddr);
    assign next_addr = req_addr + 32'd4;

    assign i_req  = ((state == StFetch) || (state == StDiscard)) && !rst;
    assign i_addr = req_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= StFetch;
            pc       <= RESET_VEC;
            req_addr <= RESET_VEC;
            buf_inst <= NOP_INST;
            buf_pc   <= 32'h0;
            p_inst   <= NOP_INST;
            p_pc     <= 32'h0;
        end else begin
            unique case (state)
                StFetch: begin
                    if (redir) begin
                        // Wrong-path fetch: bubble into ID; the delay slot already there proceeds.
                        p_inst <= NOP_INST;
                        pc     <= target;
                        if (i_ack) begin
                            req_addr <= target;
                        end else begin
                            state <= StDiscard;
                        end
                    end else if (i_ack) begin
                        pc <= next_addr;
                        if (!stall) begin
                            p_inst   <= i_data;
                            p_pc     <= req_addr;
                            req_addr <= next_addr;
                        end else begin
                            buf_inst <= i_data;
                            buf_pc   <= req_addr;
                            state    <= StHold;
                        end
                    end else if (!stall) begin
                        p_inst <= NOP_INST;
                    end
                end

                StHold: begin
                    if (redir) begin
                        p_inst   <= NOP_INST;
                        pc       <= target;
                        req_addr <= target;
                        state    <= StFetch;
                    end else if (!stall) begin
                        p_inst   <= buf_inst;
                        p_pc     <= buf_pc;
                        req_addr <= pc;
                        state    <= StFetch;
                    end
                end

                StDiscard: begin
                    if (redir) begin
                        pc <= target;
                    end
                    if (redir || !stall) begin
                        p_inst <= NOP_INST;
                    end
                    if (i_ack) begin
                        req_addr <= redir ? target : pc;
                        state    <= StFetch;
                    end
                end

                default: begin
                    state <= StFetch;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_if.sv
// Directed self-checking bench for cpu_if: zero-wait fetch, redirects,
// wait-state discard, stall skid, address wrap and asynchronous reset.
module tb_cpu_if;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        c_b;
    logic        c_j;
    logic [31:0] baddr;
    logic [31:0] jaddr;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_data;
    logic [31:0] p_inst;
    logic [31:0] p_pc;
    logic        ack_en;

    int n_checks = 0;
    int n_errors = 0;

    cpu_if #(.RESET_VEC(32'h0000_0000)) dut (
        .clk    (clk),
        .rst    (rst),
        .stall  (stall),
        .c_b    (c_b),
        .c_j    (c_j),
        .baddr  (baddr),
        .jaddr  (jaddr),
        .i_req  (i_req),
        .i_addr (i_addr),
        .i_ack  (i_ack),
        .i_data (i_data),
        .p_inst (p_inst),
        .p_pc   (p_pc)
    );

    // Memory word is the address tagged in the top nibble, so it never looks like a bubble.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return {4'hA, a[27:0]};
    endfunction

    assign i_ack  = i_req & ack_en;
    assign i_data = mem(i_addr);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst    = 1'b1;
        stall  = 1'b0;
        c_b    = 1'b0;
        c_j    = 1'b0;
        baddr  = 32'h0;
        jaddr  = 32'h0;
        ack_en = 1'b1;

        #3;
        check_eq("rst_ireq",  {31'h0, i_req}, 32'h0);
        check_eq("rst_pinst", p_inst, 32'h0);
        check_eq("rst_ppc",   p_pc,   32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check_eq("zw_ireq0", {31'h0, i_req}, 32'h1);
        check_eq("zw_addr0", i_addr, 32'h0);

        // Zero-wait streaming
        tick();
        check_eq("zw_addr1",  i_addr, 32'h4);
        check_eq("zw_ppc1",   p_pc,   32'h0);
        check_eq("zw_pinst1", p_inst, mem(32'h0));
        tick();
        check_eq("zw_addr2",  i_addr, 32'h8);
        check_eq("zw_ppc2",   p_pc,   32'h4);
        check_eq("zw_pinst2", p_inst, mem(32'h4));

        // Taken branch at i_addr=8
        c_b = 1'b1; baddr = 32'h100;
        tick();
        c_b = 1'b0;
        check_eq("br_bubble", p_inst, 32'h0);
        check_eq("br_addr",   i_addr, 32'h100);
        tick();
        check_eq("br_ppc",   p_pc,   32'h100);
        check_eq("br_pinst", p_inst, mem(32'h100));
        check_eq("br_addr2", i_addr, 32'h104);

        // Jump to 0x20, then redirect to 0x400 while the 0x20 read is waiting
        c_j = 1'b1; jaddr = 32'h20;
        tick();
        c_j = 1'b0;
        check_eq("ws_addr20", i_addr, 32'h20);
        ack_en = 1'b0;
        c_j = 1'b1; jaddr = 32'h400;
        tick();
        c_j = 1'b0;
        check_eq("ws_hold1",  i_addr, 32'h20);
        check_eq("ws_req1",   {31'h0, i_req}, 32'h1);
        check_eq("ws_bub1",   p_inst, 32'h0);
        tick();
        check_eq("ws_hold2",  i_addr, 32'h20);
        ack_en = 1'b1;
        tick();
        check_eq("ws_addr400", i_addr, 32'h400);
        check_eq("ws_bub3",    p_inst, 32'h0);
        tick();
        check_eq("ws_ppc",   p_pc,   32'h400);
        check_eq("ws_pinst", p_inst, mem(32'h400));

        // Stall in the ack cycle at 0x10
        c_j = 1'b1; jaddr = 32'h10;
        tick();
        c_j = 1'b0;
        check_eq("st_addr10", i_addr, 32'h10);
        stall = 1'b1;
        tick();
        check_eq("st_ireq0",  {31'h0, i_req}, 32'h0);
        check_eq("st_pinst0", p_inst, 32'h0);
        check_eq("st_ppc0",   p_pc,   32'h400);
        tick();
        check_eq("st_ireq1",  {31'h0, i_req}, 32'h0);
        check_eq("st_ppc1",   p_pc,   32'h400);
        stall = 1'b0;
        tick();
        check_eq("st_ppc10",   p_pc,   32'h10);
        check_eq("st_pinst10", p_inst, mem(32'h10));
        check_eq("st_addr14",  i_addr, 32'h14);
        check_eq("st_ireq2",   {31'h0, i_req}, 32'h1);
        tick();
        check_eq("st_ppc14",   p_pc,   32'h14);
        check_eq("st_pinst14", p_inst, mem(32'h14));

        // Branch and jump together; jump wins and low bits are cleared
        c_b = 1'b1; c_j = 1'b1; baddr = 32'h200; jaddr = 32'h302;
        tick();
        c_b = 1'b0; c_j = 1'b0;
        check_eq("bj_addr", i_addr, 32'h300);
        tick();
        check_eq("bj_ppc", p_pc, 32'h300);

        // PC wraps at the top of the address space
        c_j = 1'b1; jaddr = 32'hFFFF_FFFC;
        tick();
        c_j = 1'b0;
        check_eq("wr_addr_top", i_addr, 32'hFFFF_FFFC);
        tick();
        check_eq("wr_addr0", i_addr, 32'h0);
        check_eq("wr_ppc",   p_pc,   32'hFFFF_FFFC);

        // Async reset while in DISCARD
        ack_en = 1'b0;
        c_b = 1'b1; baddr = 32'h500;
        tick();
        c_b = 1'b0;
        check_eq("ar_ireq_pre", {31'h0, i_req}, 32'h1);
        check_eq("ar_addr_pre", i_addr, 32'h0);
        #2 rst = 1'b1;
        #1;
        check_eq("ar_ireq",  {31'h0, i_req}, 32'h0);
        check_eq("ar_pinst", p_inst, 32'h0);
        check_eq("ar_ppc",   p_pc,   32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        ack_en = 1'b1;
        #1;
        check_eq("ar_addr_post", i_addr, 32'h0);
        check_eq("ar_ireq_post", {31'h0, i_req}, 32'h1);
        tick();
        check_eq("ar_addr_next", i_addr, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
